// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache between Fetcher and MemCtrl.
// Latency: hit 1 cycle, miss = MemCtrl latency + 2; rdy=0 freezes every register.
// ICACHE_PERF_EN adds hit_cnt_out/miss_cnt_out decision counters.
module icache #(
    parameter int INDEX_LEN = 8,
    parameter int ADDR_LEN  = 32,
    parameter int INS_LEN   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [ADDR_LEN-1:0] pc_from_if,
    input  logic                ena_from_if,
    input  logic                drop_flag_from_if,
    output logic                ok_flag_to_if,
    output logic [INS_LEN-1:0]  inst_to_if,
    output logic [ADDR_LEN-1:0] pc_to_mc,
    output logic                ena_to_mc,
    output logic                drop_flag_to_mc,
    input  logic                ok_flag_from_mc,
    input  logic [INS_LEN-1:0]  inst_from_mc
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]         hit_cnt_out,
    output logic [31:0]         miss_cnt_out
`endif
);
    localparam int LINES   = 1 << INDEX_LEN;
    localparam int TAG_LEN = ADDR_LEN - INDEX_LEN - 2;

    typedef enum logic [1:0] {IDLE, MISS, RESP} state_t;

    state_t                state, state_n;
    logic [LINES-1:0]      valid;
    logic [TAG_LEN-1:0]    tag_arr  [LINES];
    logic [INS_LEN-1:0]    data_arr [LINES];

    logic                  ok_n, ena_mc_n, drop_mc_n, fill, hit_evt, miss_evt;
    logic [INS_LEN-1:0]    inst_n;
    logic [ADDR_LEN-1:0]   pc_mc_n;

    logic [INDEX_LEN-1:0]  idx_if, idx_mc;
    logic [TAG_LEN-1:0]    tag_if, tag_mc;
    logic                  hit;
    logic                  unused_pc_bits;

    assign idx_if = pc_from_if[INDEX_LEN+1:2];
    assign tag_if = pc_from_if[ADDR_LEN-1:INDEX_LEN+2];
    // The latched miss address doubles as the fill index/tag.
    assign idx_mc = pc_to_mc[INDEX_LEN+1:2];
    assign tag_mc = pc_to_mc[ADDR_LEN-1:INDEX_LEN+2];
    assign hit    = valid[idx_if] && (tag_arr[idx_if] == tag_if);
    assign unused_pc_bits = ^pc_from_if[1:0];

    always_comb begin
        state_n   = state;
        ok_n      = 1'b0;
        inst_n    = inst_to_if;
        pc_mc_n   = pc_to_mc;
        ena_mc_n  = ena_to_mc;
        drop_mc_n = 1'b0;
        fill      = 1'b0;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ena_from_if && !drop_flag_from_if) begin
                    if (hit) begin
                        hit_evt = 1'b1;
                        ok_n    = 1'b1;
                        inst_n  = data_arr[idx_if];
                        state_n = RESP;
                    end else begin
                        miss_evt = 1'b1;
                        ena_mc_n = 1'b1;
                        pc_mc_n  = {pc_from_if[ADDR_LEN-1:2], 2'b00};
                        state_n  = MISS;
                    end
                end
            end
            MISS: begin
                if (ok_flag_from_mc) begin
                    // The word is valid for its address even if the fetch was dropped.
                    fill     = 1'b1;
                    ena_mc_n = 1'b0;
                    if (drop_flag_from_if) begin
                        state_n = IDLE;
                    end else begin
                        ok_n    = 1'b1;
                        inst_n  = inst_from_mc;
                        state_n = RESP;
                    end
                end else if (drop_flag_from_if) begin
                    ena_mc_n  = 1'b0;
                    drop_mc_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            valid           <= '0;
            ok_flag_to_if   <= 1'b0;
            inst_to_if      <= '0;
            pc_to_mc        <= '0;
            ena_to_mc       <= 1'b0;
            drop_flag_to_mc <= 1'b0;
        end else if (rdy) begin
            state           <= state_n;
            ok_flag_to_if   <= ok_n;
            inst_to_if      <= inst_n;
            pc_to_mc        <= pc_mc_n;
            ena_to_mc       <= ena_mc_n;
            drop_flag_to_mc <= drop_mc_n;
            if (fill) valid[idx_mc] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            tag_arr[idx_mc]  <= tag_mc;
            data_arr[idx_mc] <= inst_from_mc;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_out  <= '0;
            miss_cnt_out <= '0;
        end else if (rdy) begin
            if (hit_evt)  hit_cnt_out  <= hit_cnt_out + 32'd1;
            if (miss_evt) miss_cnt_out <= miss_cnt_out + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = hit_evt ^ miss_evt;
`endif

endmodule
